vector_sweep_checker: RTL and testbench

VECTOR_SWEEP_CHECKER -- requirements
Module: vector_sweep_checker

---
 rtl/vsc_pkg.sv | 13 +
 rtl/vsc_settle_timer.sv | 28 ++
 rtl/vector_sweep_checker.sv | 127 ++++++++++++
 tb/tb_vector_sweep_checker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vsc_pkg.sv
// Shared types and constants for the vector sweep checker.
package vsc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam int unsigned SETTLE_W = 8;

endpackage

// File: rtl/vsc_settle_timer.sv
// Settle countdown: load a hold length, count down while enabled, flag the last cycle.
module vsc_settle_timer
    import vsc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                count,
    output logic                expire
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Asserted on the final counted cycle so the caller leaves after exactly load_val cycles.
    assign expire = (cnt == SETTLE_W'(1));

endmodule

// File: rtl/vector_sweep_checker.sv
// Sweeps every N-bit vector, compares DUT against golden output, counts mismatches.
// Optional: VSC_STOP_ON_FAIL_EN stops the sweep at the first mismatch.
module vector_sweep_checker
    import vsc_pkg::*;
#(
    parameter int unsigned N      = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] vec_o,
    input  logic         q_i,
    input  logic         a_i,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] first_fail
);

    localparam logic [N-1:0] VEC_MAX = '1;

    state_t state, state_nx;

    logic [N-1:0] vec_q;
    logic [N:0]   err_q;
    logic [N-1:0] ff_q;

    logic clear;
    logic adv;
    logic mismatch;
    logic tmr_load;
    logic tmr_count;
    logic tmr_expire;

    vsc_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_W'(SETTLE)),
        .count    (tmr_count),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        clear     = 1'b0;
        adv       = 1'b0;
        mismatch  = 1'b0;
        tmr_load  = 1'b0;
        tmr_count = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = DRIVE;
                    clear    = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            DRIVE: begin
                tmr_count = 1'b1;
                if (tmr_expire) begin
                    state_nx = SAMPLE;
                end
            end
            SAMPLE: begin
                mismatch = (q_i != a_i);
                if (vec_q == VEC_MAX) begin
                    state_nx = DONE;
                end else begin
                    state_nx = DRIVE;
                    adv      = 1'b1;
                    tmr_load = 1'b1;
                end
`ifdef VSC_STOP_ON_FAIL_EN
                if (mismatch) begin
                    state_nx = DONE;
                    adv      = 1'b0;
                    tmr_load = 1'b0;
                end
`endif
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q <= '0;
            err_q <= '0;
            ff_q  <= '0;
        end else if (clear) begin
            vec_q <= '0;
            err_q <= '0;
            ff_q  <= '0;
        end else begin
            if (adv) begin
                vec_q <= vec_q + 1'b1;
            end
            if (mismatch) begin
                err_q <= err_q + 1'b1;
                if (err_q == '0) begin
                    ff_q <= vec_q;
                end
            end
        end
    end

    assign vec_o      = vec_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;
    assign busy       = (state == DRIVE) || (state == SAMPLE);
    assign done       = (state == DONE);
    assign pass       = (state == DONE) && (err_q == '0);

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Directed bench: two checker instances (N=3/SETTLE=1 and N=4/SETTLE=3) with hand-computed results.
module tb_vector_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start4;
    logic       and_mode;

    logic [2:0] vec3;
    logic       q3, a3, busy3, done3, pass3;
    logic [3:0] err3;
    logic [2:0] ff3;

    logic [3:0] vec4;
    logic       q4, a4, busy4, done4, pass4;
    logic [4:0] err4;
    logic [3:0] ff4;

    int n_vec = 0;
    int n_err = 0;
    int k;
    bit found;

    always #5 clk = ~clk;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

    assign a3 = maj3(vec3);
    assign q3 = and_mode ? (&vec3) : maj3(vec3);
    assign a4 = ^vec4;
    assign q4 = ^vec4;

    vector_sweep_checker #(.N(3), .SETTLE(1)) u3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vec_o      (vec3),
        .q_i        (q3),
        .a_i        (a3),
        .busy       (busy3),
        .done       (done3),
        .pass       (pass3),
        .err_cnt    (err3),
        .first_fail (ff3)
    );

    vector_sweep_checker #(.N(4), .SETTLE(3)) u4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .vec_o      (vec4),
        .q_i        (q4),
        .a_i        (a4),
        .busy       (busy4),
        .done       (done4),
        .pass       (pass4),
        .err_cnt    (err4),
        .first_fail (ff4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Counts rising edges from the one that samples start (edge 1) until done rises.
    task automatic wait_done(input bit which, input bit hold, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 200 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (i == 1 && !hold) begin
                start  = 1'b0;
                start4 = 1'b0;
            end
            if (which ? done4 : done3) begin
                cyc = i;
                hit = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        start4   = 1'b0;
        and_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vec", vec3, 0);
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_pass", pass3, 0);
        check("rst_err", err3, 0);
        check("rst_ff", ff3, 0);
        check("rst_done4", done4, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Matching devices: full clean sweep
        @(negedge clk);
        start = 1'b1;
        wait_done(1'b0, 1'b0, k);
        check("maj_latency", k, 17);
        check("maj_pass", pass3, 1);
        check("maj_err", err3, 0);
        check("maj_vec", vec3, 7);
        check("maj_busy", busy3, 0);
        repeat (3) @(posedge clk);
        #1;
        check("maj_hold_done", done3, 1);
        check("maj_hold_pass", pass3, 1);
        check("maj_hold_vec", vec3, 7);

        // AND vs majority differs at 011, 101, 110
        and_mode = 1'b1;
        @(negedge clk);
        start = 1'b1;
        wait_done(1'b0, 1'b0, k);
`ifdef VSC_STOP_ON_FAIL_EN
        check("and_latency", k, 9);
        check("and_err", err3, 1);
        check("and_vec", vec3, 3);
`else
        check("and_latency", k, 17);
        check("and_err", err3, 3);
        check("and_vec", vec3, 7);
`endif
        check("and_ff", ff3, 3);
        check("and_pass", pass3, 0);
        check("and_done", done3, 1);

        // Reset mid-sweep at vector 101
`ifdef VSC_STOP_ON_FAIL_EN
        and_mode = 1'b0;
`else
        and_mode = 1'b1;
`endif
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (vec3 == 3'b101) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("mid_reached_101", found, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_vec", vec3, 0);
        check("mid_rst_busy", busy3, 0);
        check("mid_rst_done", done3, 0);
        check("mid_rst_pass", pass3, 0);
        check("mid_rst_err", err3, 0);
        check("mid_rst_ff", ff3, 0);
        and_mode = 1'b0;
        @(negedge clk);
        start = 1'b1;
        wait_done(1'b0, 1'b0, k);
        check("post_rst_latency", k, 17);
        check("post_rst_pass", pass3, 1);
        check("post_rst_err", err3, 0);

        // Start held high: one sweep, then restart from DONE clears the count
        and_mode = 1'b1;
        @(negedge clk);
        start = 1'b1;
        wait_done(1'b0, 1'b1, k);
`ifdef VSC_STOP_ON_FAIL_EN
        check("hold_latency", k, 9);
        check("hold_err", err3, 1);
`else
        check("hold_latency", k, 17);
        check("hold_err", err3, 3);
`endif
        @(posedge clk);
        #1;
        check("restart_busy", busy3, 1);
        check("restart_done", done3, 0);
        check("restart_err", err3, 0);
        check("restart_vec", vec3, 0);
        start    = 1'b0;
        and_mode = 1'b0;
        wait_done(1'b0, 1'b0, k);
        check("restart_latency", k, 16);
        check("restart_pass", pass3, 1);

        // N=4, SETTLE=3 parity sweep
        @(negedge clk);
        start4 = 1'b1;
        wait_done(1'b1, 1'b0, k);
        check("n4_latency", k, 65);
        check("n4_err", err4, 0);
        check("n4_pass", pass4, 1);
        check("n4_vec", vec4, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
